mdu_seq: RTL
============

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS core (MULT/MULTU/DIV/DIVU).
- Owns no adder. It drives the shared 32-bit ALU through its a/b/aluop inputs and consumes its result, one add or subtract per cycle.
- It writes the HI/LO results and signals completion with a start/busy/done handshake to the pipeline controller.

Parameters:
- ALU_ADD, 4'b0000, aluop code for a+b
- ALU_SUB, 4'b0010, aluop code for a-b (a + ~b + 1)
- ITER, 32, iteration count; must equal operand width (only 32 supported)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  high while iterating
- done  out  1  one-cycle completion pulse
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- div_by_zero  out  1  sticky flag for last divide with src_b==0; cleared on next accepted start
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  4  ALU opcode
- alu_result  in  32  ALU result (combinational from alu_a/alu_b/alu_op)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, div_by_zero = 0; hi, lo, counter, internal operand register = 0; alu_a, alu_b = 0; alu_op = ALU_ADD.
- State machine: IDLE, MUL, DIV, FINISH.
- Accepting a request: start=1 in IDLE at edge N latches the operands, clears div_by_zero and the counter, and moves to MUL or DIV per op. start in any other state is ignored with no effect.
- Divide by zero: when op=1 and src_b==0, go to FINISH directly with hi=src_a, lo=32'hFFFFFFFF, div_by_zero=1. done is high in the cycle after N.
- MUL: hi=0 and lo=src_a at load; mcand=src_b.
  - Each cycle: alu_a=hi, alu_b=mcand, alu_op=ALU_ADD.
  - carry = (a31&b31) | ((a31|b31) & ~result31).
  - If lo[0]=1: {hi,lo} <= {carry, alu_result, lo[31:1]} >> 0 (i.e. 65-bit right shift of {carry,alu_result,lo}).
  - Otherwise: {hi,lo} <= {1'b0, hi, lo} >> 1.
- DIV (restoring): hi=0 and lo=src_a at load.
  - Each cycle: shifted={hi[30:0],lo[31]}, top=hi[31], alu_a=shifted, alu_b=divisor, alu_op=ALU_SUB.
  - nb = (a31&~b31) | ((a31|~b31) & ~result31).
  - If top|nb: hi<=alu_result, lo<={lo[30:0],1}.
  - Otherwise: hi<=shifted, lo<={lo[30:0],0}.
- Counter and completion: the counter increments every iteration. After the ITER-th iteration the state moves to FINISH.
  - done=1 for exactly the FINISH cycle, then IDLE.
  - Normal latency: start edge N gives done high in cycle N+33.
- busy: 1 in MUL/DIV, 0 in IDLE/FINISH.
- Outputs outside MUL/DIV: alu_a=0, alu_b=0, alu_op=ALU_ADD.
- Result hold: hi/lo/div_by_zero hold until the next accepted start.
- Reset mid-operation: immediate return to reset values. No done pulse.
- Back-to-back: start may be asserted in the cycle after done (IDLE). No request is lost or doubled.

Optional Feature:
- Macro: SIGNED_MD_EN.
- Defined:
  - Adds input port op_signed (1 bit), sampled with start.
  - When op_signed=1, operands load as absolute values and the sign flags are latched.
  - An extra FIX state between the last iteration and FINISH negates results: product if a31^b31; quotient if a31^b31; remainder if a31.
  - FIX is entered on every operation, so latency is always N+34.
  - Divide-by-zero result is unchanged.
- Undefined: no op_signed port, no FIX state, unsigned only, latency N+33.

Test Plan:
- Multiply: start, op=0, a=7, b=6 -> done at N+33; hi=0, lo=42; busy high for exactly 32 cycles.
- Multiply: a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises carry).
- Divide: op=1, a=100, b=7 -> lo=14, hi=2, div_by_zero=0; alu_op=4'b0010 during all 32 busy cycles.
- Divide by zero: a=5, b=0 -> done at N+1; hi=5, lo=32'hFFFFFFFF, div_by_zero=1. A following start clears div_by_zero.
- Ignored start and reset: a second start pulse at N+10 is ignored and the result equals the first operation's. rst_n low at N+15 -> busy=0, hi=lo=0, no done; a new operation afterwards completes correctly.
- SIGNED_MD_EN: op_signed=1, divide -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF at N+34. Multiply -3*5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer for the MIPS core.
//
// Executes MULT/MULTU/DIV/DIVU by issuing one add or subtract per cycle to the
// shared 32-bit ALU. The ALU is outside this block. The sequencer writes HI/LO
// and reports completion through a start/busy/done handshake.
//
// Optional feature macro: SIGNED_MD_EN
//   Defined   : adds the op_signed input and a FIX state that corrects result
//               signs. Every operation then has latency N+34.
//   Undefined : unsigned only, latency N+33.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request pulse, sampled only in IDLE
//   op           in   0 = multiply, 1 = divide
//   op_signed    in   (SIGNED_MD_EN only) signed operation, sampled with start
//   src_a        in   multiplicand / dividend
//   src_b        in   multiplier / divisor
//   busy         out  high while iterating
//   done         out  one-cycle completion pulse
//   hi           out  product[63:32] / remainder
//   lo           out  product[31:0] / quotient
//   div_by_zero  out  sticky flag for the last divide by zero
//   alu_a        out  ALU operand a
//   alu_b        out  ALU operand b
//   alu_op       out  ALU opcode
//   alu_result   in   combinational ALU result
module mdu_seq #(
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0010,
  parameter int         ITER    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
`ifdef SIGNED_MD_EN
  input  logic        op_signed,
`endif
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result
);

`ifdef SIGNED_MD_EN
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, FINISH} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;
`endif

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] operand;
  logic [31:0] shifted;
  logic        top;
  logic        carry;
  logic        nb;
  logic [31:0] load_a;
  logic [31:0] load_b;

`ifdef SIGNED_MD_EN
  logic        sign_a;
  logic        sign_b;
  logic        is_div;
  logic [63:0] prod_neg;
`endif

  // Load values for the operand registers. In signed mode, negative operands
  // are loaded as magnitudes. FIX restores the signs after the iterations.
`ifdef SIGNED_MD_EN
  always_comb begin
    load_a = (op_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    load_b = (op_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
    prod_neg = ~{hi, lo} + 64'd1;
  end
`else
  always_comb begin
    load_a = src_a;
    load_b = src_b;
  end
`endif

  // Drive the ALU operands and opcode from the current state.
  // carry is the carry-out of the add, rebuilt from the operand sign bits
  // and the result sign bit.
  // nb is the no-borrow flag of the subtract, meaning shifted >= divisor.
  always_comb begin
    shifted = {hi[30:0], lo[31]};
    top     = hi[31];
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    alu_op  = ALU_ADD;
    case (state)
      MUL: begin
        alu_a  = hi;
        alu_b  = operand;
        alu_op = ALU_ADD;
      end
      DIV: begin
        alu_a  = shifted;
        alu_b  = operand;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
    carry = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_result[31]);
    nb    = (alu_a[31] & ~alu_b[31]) | ((alu_a[31] | ~alu_b[31]) & ~alu_result[31]);
  end

  // Sequencer FSM. busy and done are registered.
  // - Multiply: shift-add. The product shifts down through {hi,lo}.
  // - Divide: restoring. The quotient bits shift in at the bottom of lo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      cnt         <= 6'd0;
      operand     <= 32'd0;
`ifdef SIGNED_MD_EN
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      is_div      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_by_zero <= 1'b0;
            cnt         <= 6'd0;
`ifdef SIGNED_MD_EN
            sign_a      <= op_signed & src_a[31];
            sign_b      <= op_signed & src_b[31];
            is_div      <= op;
`endif
            if (op && (src_b == 32'd0)) begin
              hi          <= src_a;
              lo          <= 32'hFFFF_FFFF;
              operand     <= 32'd0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= FINISH;
            end else begin
              hi      <= 32'd0;
              lo      <= load_a;
              operand <= load_b;
              busy    <= 1'b1;
              state   <= op ? DIV : MUL;
            end
          end
        end

        MUL, DIV: begin
          cnt <= cnt + 6'd1;
          if (state == MUL) begin
            if (lo[0]) begin
              hi <= {carry, alu_result[31:1]};
              lo <= {alu_result[0], lo[31:1]};
            end else begin
              hi <= {1'b0, hi[31:1]};
              lo <= {hi[0], lo[31:1]};
            end
          end else begin
            if (top | nb) begin
              hi <= alu_result;
              lo <= {lo[30:0], 1'b1};
            end else begin
              hi <= shifted;
              lo <= {lo[30:0], 1'b0};
            end
          end
          if (cnt == LAST) begin
            busy  <= 1'b0;
`ifdef SIGNED_MD_EN
            state <= FIX;
`else
            done  <= 1'b1;
            state <= FINISH;
`endif
          end
        end

`ifdef SIGNED_MD_EN
        FIX: begin
          if (is_div) begin
            if (sign_a ^ sign_b) lo <= ~lo + 32'd1;
            if (sign_a)          hi <= ~hi + 32'd1;
          end else if (sign_a ^ sign_b) begin
            {hi, lo} <= prod_neg;
          end
          done  <= 1'b1;
          state <= FINISH;
        end
`endif

        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
